// File: rtl/adc_capture_seq.sv
// Multi-channel ADC capture sequencer: latches one frame per accepted din_valid,
// serialises the enabled channels into a word stream and frames it into records.
module adc_capture_seq #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     mode_cont_i,
    input  logic [NUM_CH-1:0]        ch_mask_i,
    input  logic [LEN_W-1:0]         rec_len_i,
    input  logic [NUM_CH*DATA_W-1:0] din_i,
    input  logic                     din_valid_i,
    input  logic                     full_i,
    output logic                     wr_en_o,
    output logic [DATA_W-1:0]        dout_o,
    output logic                     sof_o,
    output logic                     eof_o,
    output logic                     busy_o,
    output logic                     overflow_o,
    output logic [LEN_W-1:0]         rec_cnt_o
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [NUM_CH-1:0]          mask_q, mask_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic                       cont_q, cont_d;
    logic [NUM_CH*DATA_W-1:0]   hold_q, hold_d;
    logic                       hold_first_q, hold_first_d;
    logic                       hold_last_q, hold_last_d;
    logic [NUM_CH-1:0]          pending_q, pending_d;
    logic [LEN_W-1:0]           frame_cnt_q, frame_cnt_d;
    logic [LEN_W-1:0]           rec_cnt_q, rec_cnt_d;
    logic                       stop_req_q, stop_req_d;
    logic                       overflow_q, overflow_d;
    logic                       wr_en_q, wr_en_d;
    logic [DATA_W-1:0]          dout_q, dout_d;
    logic                       sof_q, sof_d;
    logic                       eof_q, eof_d;

    logic                       use_hold;
    logic [NUM_CH-1:0]          src_mask, lowbit, rest_mask, pend_after_old;
    logic                       emit_old, emit_new, emit;
    logic                       rec_open, accept, drop, accept_last;
    logic                       src_first, src_last, word_first, word_last;
    logic                       eof_emit, stop_any, start_ok, restart;
    logic [IDX_W-1:0]           sel_idx;
    logic [DATA_W-1:0]          src_ch [NUM_CH];
    logic [DATA_W-1:0]          src_word;

    // With nothing pending, an accepted frame emits its first word straight from din.
    assign use_hold       = |pending_q;
    assign src_mask       = use_hold ? pending_q : mask_q;
    assign lowbit         = src_mask & (~src_mask + NUM_CH'(1));
    assign rest_mask      = src_mask & ~lowbit;
    assign emit_old       = use_hold & ~full_i;
    assign pend_after_old = emit_old ? rest_mask : pending_q;

    assign rec_open    = (frame_cnt_q != len_q);
    assign accept      = (state_q == CAPTURE) & din_valid_i & rec_open & (pend_after_old == '0);
    assign drop        = (state_q == CAPTURE) & din_valid_i & rec_open & (pend_after_old != '0);
    assign accept_last = ((frame_cnt_q + LEN_W'(1)) == len_q);
    assign emit_new    = ~use_hold & accept & ~full_i;
    assign emit        = emit_old | emit_new;

    assign src_first  = use_hold ? hold_first_q : (frame_cnt_q == '0);
    assign src_last   = use_hold ? hold_last_q : accept_last;
    assign word_first = use_hold ? (pending_q == mask_q) : 1'b1;
    assign word_last  = (rest_mask == '0);
    assign eof_emit   = emit & src_last & word_last;

    assign stop_any = stop_req_q | stop_i;
    assign start_ok = (state_q == IDLE) & start_i & (|ch_mask_i) & (|rec_len_i);
    assign restart  = eof_emit & cont_q & ~stop_any;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_src_ch
        assign src_ch[gi] = use_hold ? hold_q[gi*DATA_W +: DATA_W] : din_i[gi*DATA_W +: DATA_W];
    end

    always_comb begin
        sel_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (src_mask[i]) sel_idx = IDX_W'(i);
        end
    end

    assign src_word = src_ch[sel_idx];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = CAPTURE;
            CAPTURE: begin
                if (eof_emit)                  state_d = restart ? CAPTURE : IDLE;
                else if (accept && accept_last) state_d = DRAIN;
            end
            DRAIN:   if (eof_emit) state_d = restart ? CAPTURE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en_d = emit;
        dout_d  = emit ? src_word : dout_q;
        sof_d   = emit & src_first & word_first;
        eof_d   = eof_emit;
    end

    always_comb begin
        mask_d       = mask_q;
        len_d        = len_q;
        cont_d       = cont_q;
        hold_d       = hold_q;
        hold_first_d = hold_first_q;
        hold_last_d  = hold_last_q;
        pending_d    = pend_after_old;
        frame_cnt_d  = frame_cnt_q;
        rec_cnt_d    = rec_cnt_q;
        stop_req_d   = stop_req_q;
        overflow_d   = overflow_q;
        if (start_ok) begin
            mask_d      = ch_mask_i;
            len_d       = rec_len_i;
            cont_d      = mode_cont_i;
            frame_cnt_d = '0;
            rec_cnt_d   = '0;
            stop_req_d  = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (state_q != IDLE && stop_i) stop_req_d = 1'b1;
            if (drop) overflow_d = 1'b1;
            if (accept) begin
                hold_d       = din_i;
                hold_first_d = (frame_cnt_q == '0);
                hold_last_d  = accept_last;
                pending_d    = emit_new ? (mask_q & ~lowbit) : mask_q;
                frame_cnt_d  = frame_cnt_q + LEN_W'(1);
            end
            if (eof_emit) begin
                rec_cnt_d = rec_cnt_q + LEN_W'(1);
                if (restart) frame_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mask_q       <= '0;
            len_q        <= '0;
            cont_q       <= 1'b0;
            hold_q       <= '0;
            hold_first_q <= 1'b0;
            hold_last_q  <= 1'b0;
            pending_q    <= '0;
            frame_cnt_q  <= '0;
            rec_cnt_q    <= '0;
            stop_req_q   <= 1'b0;
            overflow_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            dout_q       <= '0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
        end else begin
            mask_q       <= mask_d;
            len_q        <= len_d;
            cont_q       <= cont_d;
            hold_q       <= hold_d;
            hold_first_q <= hold_first_d;
            hold_last_q  <= hold_last_d;
            pending_q    <= pending_d;
            frame_cnt_q  <= frame_cnt_d;
            rec_cnt_q    <= rec_cnt_d;
            stop_req_q   <= stop_req_d;
            overflow_q   <= overflow_d;
            wr_en_q      <= wr_en_d;
            dout_q       <= dout_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
        end
    end

    assign wr_en_o    = wr_en_q;
    assign dout_o     = dout_q;
    assign sof_o      = sof_q;
    assign eof_o      = eof_q;
    assign busy_o     = (state_q != IDLE);
    assign overflow_o = overflow_q;
    assign rec_cnt_o  = rec_cnt_q;

endmodule
